// File: rtl/maverickOne_pkg.sv
// rtl/maverickOne_pkg.sv - shared constants, tag type and write-back port struct
package maverickOne_pkg;

  localparam int NUM_REGS = 64;
  localparam int XLEN     = 64;
  localparam int TAG_W    = 4;
  localparam int REG_AW   = $clog2(NUM_REGS);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] addr;
    tag_t              tag;
    logic [XLEN-1:0]   data;
  } wb_port_t;

endpackage

// File: rtl/regfile_sb_wb_resolve.sv
// rtl/regfile_sb_wb_resolve.sv - tag match and port priority for write-backs
module regfile_sb_wb_resolve
  import maverickOne_pkg::*;
#(
  parameter int NR  = NUM_REGS,
  parameter int DW  = XLEN,
  parameter int TW  = TAG_W,
  parameter int NWP = 2
) (
  input  wb_port_t          wb_i     [NWP],
  input  logic [NR-1:0]     locks_i,
  input  logic [TW-1:0]     tags_i   [NR],
  output logic [NR-1:0]     we_o,
  output logic [DW-1:0]     data_o   [NR],
  output logic [NR-1:0]     unlock_o,
  output logic [NWP-1:0]    stale_o,
  output logic              conflict_o
);

  logic [NWP-1:0] match;

  always_comb begin
    match   = '0;
    stale_o = '0;
    for (int p = 0; p < NWP; p++) begin
      if (wb_i[p].en && wb_i[p].addr != '0) begin
        if (locks_i[wb_i[p].addr] && wb_i[p].tag == tags_i[wb_i[p].addr])
          match[p] = 1'b1;
        else
          stale_o[p] = 1'b1;
      end
    end
  end

  // Ascending scan so the highest-index matching port overwrites earlier ones.
  always_comb begin
    we_o       = '0;
    conflict_o = 1'b0;
    for (int r = 0; r < NR; r++) data_o[r] = '0;
    for (int p = 0; p < NWP; p++) begin
      if (match[p]) begin
        if (we_o[wb_i[p].addr]) conflict_o = 1'b1;
        we_o[wb_i[p].addr]   = 1'b1;
        data_o[wb_i[p].addr] = wb_i[p].data;
      end
    end
    unlock_o = we_o;
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - scoreboarded register file with owner tags and read bypass
module regfile_sb
  import maverickOne_pkg::*;
#(
  parameter  int NR  = NUM_REGS,
  parameter  int DW  = XLEN,
  parameter  int NRP = 3,
  parameter  int NWP = 2,
  parameter  int TW  = TAG_W,
  localparam int AW  = $clog2(NR)
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    lock_en_i,
  input  logic [AW-1:0]           lock_addr_i,
  input  logic [TW-1:0]           lock_tag_i,
  input  logic [NWP-1:0]          wb_en_i,
  input  logic [NWP-1:0][AW-1:0]  wb_addr_i,
  input  logic [NWP-1:0][TW-1:0]  wb_tag_i,
  input  logic [NWP-1:0][DW-1:0]  wb_data_i,
  input  logic [NRP-1:0][AW-1:0]  rd_addr_i,
  output logic [NRP-1:0][DW-1:0]  rd_data_o,
  output logic [NR-1:0]           locks_o,
  output logic [15:0]             stale_cnt_o
);

  logic [DW-1:0] regs_q [NR];
  logic [DW-1:0] regs_d [NR];
  logic [TW-1:0] tags_q [NR];
  logic [TW-1:0] tags_d [NR];
  logic [NR-1:0] locks_q, locks_d;
  logic [15:0]   stale_q, stale_d;

  wb_port_t       wb_ports [NWP];
  logic [NR-1:0]  wb_we, wb_unlock;
  logic [DW-1:0]  wb_data [NR];
  logic [NWP-1:0] wb_stale;
  logic           wb_conflict;

  always_comb begin
    for (int p = 0; p < NWP; p++) begin
      wb_ports[p].en   = wb_en_i[p];
      wb_ports[p].addr = wb_addr_i[p];
      wb_ports[p].tag  = wb_tag_i[p];
      wb_ports[p].data = wb_data_i[p];
    end
  end

  regfile_sb_wb_resolve #(
    .NR  (NR),
    .DW  (DW),
    .TW  (TW),
    .NWP (NWP)
  ) u_resolve (
    .wb_i       (wb_ports),
    .locks_i    (locks_q),
    .tags_i     (tags_q),
    .we_o       (wb_we),
    .data_o     (wb_data),
    .unlock_o   (wb_unlock),
    .stale_o    (wb_stale),
    .conflict_o (wb_conflict)
  );

  logic [16:0] stale_sum;

  // A same-cycle lock is applied after the unlock so it keeps the bit set.
  always_comb begin
    regs_d  = regs_q;
    tags_d  = tags_q;
    locks_d = locks_q & ~wb_unlock;
    for (int r = 1; r < NR; r++)
      if (wb_we[r]) regs_d[r] = wb_data[r];
    if (lock_en_i && lock_addr_i != '0) begin
      locks_d[lock_addr_i] = 1'b1;
      tags_d[lock_addr_i]  = lock_tag_i;
    end
    stale_sum = {1'b0, stale_q};
    for (int p = 0; p < NWP; p++)
      stale_sum = stale_sum + 17'(wb_stale[p]);
    stale_d = stale_sum[16] ? 16'hFFFF : stale_sum[15:0];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      regs_q  <= '{default: '0};
      tags_q  <= '{default: '0};
      locks_q <= '0;
      stale_q <= '0;
    end else begin
      regs_q  <= regs_d;
      tags_q  <= tags_d;
      locks_q <= locks_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NRP; r++) begin
      if (arst_i)                rd_data_o[r] = '0;
      else if (wb_we[rd_addr_i[r]]) rd_data_o[r] = wb_data[rd_addr_i[r]];
      else                       rd_data_o[r] = regs_q[rd_addr_i[r]];
    end
    locks_o = arst_i ? '1 : ((locks_q & ~wb_unlock) & ~NR'(1));
  end

  assign stale_cnt_o = stale_q;

  always @(posedge clk_i) begin
    if (!arst_i)
      assert (!wb_conflict)
        else $warning("regfile_sb: multiple matching write-backs to one register");
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

  logic                 clk = 1'b0;
  logic                 arst;
  logic                 lock_en;
  logic [5:0]           lock_addr;
  logic [3:0]           lock_tag;
  logic [1:0]           wb_en;
  logic [1:0][5:0]      wb_addr;
  logic [1:0][3:0]      wb_tag;
  logic [1:0][63:0]     wb_data;
  logic [2:0][5:0]      rd_addr;
  logic [2:0][63:0]     rd_data;
  logic [63:0]          locks;
  logic [15:0]          stale_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .lock_en_i   (lock_en),
    .lock_addr_i (lock_addr),
    .lock_tag_i  (lock_tag),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_tag_i    (wb_tag),
    .wb_data_i   (wb_data),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .locks_o     (locks),
    .stale_cnt_o (stale_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    lock_en = 1'b0; lock_addr = '0; lock_tag = '0;
    wb_en = '0; wb_addr = '0; wb_tag = '0; wb_data = '0;
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks happen 2 ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lock(input logic [5:0] a, input logic [3:0] t);
    lock_en = 1'b1; lock_addr = a; lock_tag = t;
  endtask

  task automatic wb(input int p, input logic [5:0] a, input logic [3:0] t, input logic [63:0] d);
    wb_en[p] = 1'b1; wb_addr[p] = a; wb_tag[p] = t; wb_data[p] = d;
  endtask

  initial begin
    idle();
    rd_addr = '0;
    arst = 1'b1;
    #2;
    chk("rst_locks_ones", locks, {64{1'b1}});
    chk("rst_rd_zero", rd_data[0], 64'h0);
    tick();
    arst = 1'b0;
    #1;
    chk("post_rst_locks", locks, 64'h0);
    chk("post_rst_stale", {48'h0, stale_cnt}, 64'h0);

    // basic lock then matching write-back with bypass
    tick(); lock(6'd5, 4'd3);
    tick(); idle(); wb(0, 6'd5, 4'd3, 64'hDEAD); rd_addr[0] = 6'd5;
    #1;
    chk("x5_bypass", rd_data[0], 64'hDEAD);
    chk("x5_lock_clear_now", 64'(locks[5]), 64'h0);
    tick(); idle();
    #1;
    chk("x5_stored", rd_data[0], 64'hDEAD);
    chk("x5_lock_after", 64'(locks[5]), 64'h0);
    chk("x5_stale", {48'h0, stale_cnt}, 64'h0);

    // stale tag after re-lock
    lock(6'd7, 4'd1);
    tick(); lock(6'd7, 4'd2);
    tick(); idle(); wb(0, 6'd7, 4'd1, 64'h11); rd_addr[0] = 6'd7;
    #1;
    chk("x7_no_bypass", rd_data[0], 64'h0);
    chk("x7_still_locked_now", 64'(locks[7]), 64'h1);
    tick(); idle();
    #1;
    chk("x7_unchanged", rd_data[0], 64'h0);
    chk("x7_locked", 64'(locks[7]), 64'h1);
    chk("x7_stale1", {48'h0, stale_cnt}, 64'h1);
    wb(0, 6'd7, 4'd2, 64'h22);
    #1;
    chk("x7_bypass22", rd_data[0], 64'h22);
    tick(); idle();
    #1;
    chk("x7_stored22", rd_data[0], 64'h22);
    chk("x7_unlocked", 64'(locks[7]), 64'h0);

    // same-cycle lock and matching write-back
    lock(6'd9, 4'd6);
    tick(); idle(); lock(6'd9, 4'd4); wb(0, 6'd9, 4'd6, 64'h99); rd_addr[0] = 6'd9;
    #1;
    chk("x9_bypass", rd_data[0], 64'h99);
    chk("x9_lock_now", 64'(locks[9]), 64'h0);
    tick(); idle();
    #1;
    chk("x9_stored", rd_data[0], 64'h99);
    chk("x9_relocked", 64'(locks[9]), 64'h1);
    wb(0, 6'd9, 4'd6, 64'h55);
    tick(); idle();
    #1;
    chk("x9_oldtag_dropped", rd_data[0], 64'h99);
    chk("x9_stale2", {48'h0, stale_cnt}, 64'h2);
    wb(1, 6'd9, 4'd4, 64'h77);
    tick(); idle();
    #1;
    chk("x9_newtag_data", rd_data[0], 64'h77);
    chk("x9_unlocked", 64'(locks[9]), 64'h0);

    // two matching ports to one register: highest port wins, no stale count
    lock(6'd3, 4'd5);
    tick(); idle(); wb(0, 6'd3, 4'd5, 64'hA); wb(1, 6'd3, 4'd5, 64'hB); rd_addr[1] = 6'd3;
    #1;
    chk("x3_bypass_hi", rd_data[1], 64'hB);
    tick(); idle();
    #1;
    chk("x3_stored_hi", rd_data[1], 64'hB);
    chk("x3_unlocked", 64'(locks[3]), 64'h0);
    chk("x3_stale_same", {48'h0, stale_cnt}, 64'h2);

    // register 0 is never locked or written
    lock(6'd0, 4'd1); wb(0, 6'd0, 4'd1, 64'hFF); rd_addr[2] = 6'd0;
    #1;
    chk("x0_lock_now", 64'(locks[0]), 64'h0);
    chk("x0_rd_now", rd_data[2], 64'h0);
    tick(); idle();
    #1;
    chk("x0_lock_after", 64'(locks[0]), 64'h0);
    chk("x0_rd_after", rd_data[2], 64'h0);
    chk("x0_stale_same", {48'h0, stale_cnt}, 64'h2);

    // both ports dropped in one cycle count twice
    wb(0, 6'd12, 4'd0, 64'h1); wb(1, 6'd13, 4'd0, 64'h2);
    tick(); idle();
    #1;
    chk("dual_stale", {48'h0, stale_cnt}, 64'h4);

    // asynchronous reset mid-operation
    lock(6'd4, 4'd2);
    tick(); idle(); wb(0, 6'd4, 4'd2, 64'h44);
    tick(); idle(); lock(6'd4, 4'd7);
    tick(); idle(); rd_addr[2] = 6'd4;
    #1;
    chk("x4_before_rst", rd_data[2], 64'h44);
    chk("x4_locked", 64'(locks[4]), 64'h1);
    arst = 1'b1;
    #1;
    chk("mid_rst_locks", locks, {64{1'b1}});
    chk("mid_rst_rd", rd_data[2], 64'h0);
    #1;
    arst = 1'b0;
    #1;
    chk("after_rst_x4", rd_data[2], 64'h0);
    chk("after_rst_locks", locks, 64'h0);
    chk("after_rst_stale", {48'h0, stale_cnt}, 64'h0);
    tick();
    chk("after_rst_x4_clk", rd_data[2], 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised, scoreboarded integer register file; successor to the single-port lock/unlock register file.
- Adds configurable read and write-back port counts and per-register owner tags, so write-backs can complete out of order.
- Adds a same-cycle bypass from write-back to read.
- Sits between the decode/issue stage (lock, reads) and the execution units (write-backs); issue uses locks_o to stall.

Parameters:
- NR, 64, number of registers; register 0 is hardwired to zero.
- DW, 64, data width.
- NRP, 3, number of read ports.
- NWP, 2, number of write-back ports.
- TW, 4, owner tag width.
- AW, $clog2(NR), address width (derived, localparam).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high.
- lock_en_i  in  1  install owner tag on lock_addr_i.
- lock_addr_i  in  AW  register to lock.
- lock_tag_i  in  TW  tag of the issuing instruction.
- wb_en_i  in  NWP  per-port write-back valid.
- wb_addr_i  in  NWP x AW  write-back destination.
- wb_tag_i  in  NWP x TW  write-back tag.
- wb_data_i  in  NWP x DW  write-back data.
- rd_addr_i  in  NRP x AW  read addresses.
- rd_data_o  out  NRP x DW  read data.
- locks_o  out  NR  per-register lock status.
- stale_cnt_o  out  16  saturating count of dropped write-backs.

Behaviour:
- Reset (arst_i high, asynchronous):
  - All registers, lock bits and owner tags go to 0; stale_cnt_o goes to 0.
  - While arst_i is high, locks_o = all ones and rd_data_o = 0.
- Register 0:
  - Never locked; write-backs to it are ignored and not counted as stale.
  - Reads of it return 0.
- Write-back port p is a match when wb_en_i[p], the destination register is locked, and wb_tag_i[p] equals the stored owner tag (the owner tag before any same-cycle lock).
- Matching write-back: the register takes wb_data_i[p] at the next posedge and its lock clears, unless a same-cycle lock targets the same register.
- Non-matching write-back to a nonzero register (unlocked, or tag mismatch):
  - Data is dropped.
  - stale_cnt_o increments by 1 per dropped port per cycle, saturating at 0xFFFF.
- Lock: lock_en_i on a nonzero address sets the lock bit and stores lock_tag_i at the next posedge.
- Lock and matching write-back to the same register in the same cycle:
  - The data is written.
  - The lock bit stays set and the owner tag becomes lock_tag_i.
- Two or more matching ports to the same register in the same cycle:
  - The highest-index port wins.
  - The other ports are dropped without counting (an illegal condition, flagged by an assertion).
- Read bypass (combinational, zero latency):
  - If a matching write-back targets rd_addr_i[r] this cycle, rd_data_o[r] = that port's data (highest-index match wins).
  - Otherwise rd_data_o[r] = the stored value.
  - Non-matching write-backs never bypass.
- locks_o:
  - When arst_i is low, locks_o = stored locks with this cycle's matching write-backs' bits cleared.
  - The same-cycle lock is not reflected until the next cycle.
  - locks_o[0] = 0.
- All state updates at posedge clk_i; no other latency.

Decomposition:
- In maverickOne_pkg:
  - NUM_REGS, XLEN, TAG_W constants.
  - A tag typedef.
  - A write-back struct {en, addr, tag, data}, so write-back ports are an unpacked array of that struct.
- One sub-module, regfile_sb_wb_resolve: per-register match and priority resolution across the NWP ports.
  - Outputs per register: write enable, data, unlock.
  - Outputs per port: stale flag.
  - The top instantiates it once and reuses its per-register data/valid for the bypass.

Test Plan:
- Reset, then lock x5 with tag 3; next cycle wb port 0 {x5, tag 3, 0xDEAD} -> rd_data_o for x5 reads 0xDEAD in the same cycle; locks_o[5] is 0 in that cycle and afterwards; stale_cnt_o = 0.
- Lock x7 tag 1, then lock x7 tag 2; wb {x7, tag 1, 0x11} -> x7 unchanged (0), locks_o[7] = 1, stale_cnt_o = 1; then wb {x7, tag 2, 0x22} -> x7 = 0x22, unlocked.
- Same cycle: lock x9 tag 4 and matching wb to x9 with its old tag 6 and data 0x99 -> x9 = 0x99, locks_o[9] = 1, owner tag 4 (a later tag-4 wb unlocks x9).
- Ports 0 and 1 both write x3 with matching tag, data 0xA and 0xB -> x3 = 0xB; a read of x3 that cycle returns 0xB.
- Lock x0 tag 1 and wb {x0, 0xFF} -> locks_o[0] = 0, x0 reads 0, stale_cnt_o unchanged.
- Assert arst_i mid-operation with x4 locked and holding 0x44 -> locks_o = all ones and rd_data_o = 0 immediately; after release, x4 = 0, all unlocked, stale_cnt_o = 0.
